spi_tx_arbiter: RTL and testbench

- Shares one 12-bit SPI serial transmitter (newd/din in, cs out) between NREQ requesters.
- Grants round-robin and latches the winner's word.
- Drives newd/din until the transmitter asserts cs (low), then waits for cs to return high and reports completion per requester.
- Sits between system requesters and the SPI transmitter instance in the same clk domain.

---
 rtl/spi_arb_pkg.sv | 16 +
 rtl/spi_rr_pick.sv | 43 ++++
 rtl/spi_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_spi_tx_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI transmitter arbiter.
//   state_t           : arbiter FSM encoding
//   SPI_DW            : default SPI word width (must match the transmitter)
//   DEF_START_TIMEOUT : default clk cycles from issue to cs falling before abort
package spi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      WAIT_START = 2'b01,
      WAIT_END   = 2'b10
   } state_t;

   localparam int SPI_DW            = 12;
   localparam int DEF_START_TIMEOUT = 255;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin selector.
// Picks the lowest-index active request at or above ptr, wrapping to 0.
// Ports:
//   req    in  NREQ  active requests
//   ptr    in  PW    round-robin start position
//   valid  out 1     at least one request active
//   onehot out NREQ  one-hot winner
//   idx    out PW    binary winner index
module spi_rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic            valid,
   output logic [NREQ-1:0] onehot,
   output logic [PW-1:0]   idx
);

   // Scan from farthest to nearest so the candidate closest to ptr
   // overwrites any earlier hit.
   always_comb begin
      int            cand;
      logic [PW-1:0] c;
      valid  = 1'b0;
      onehot = '0;
      idx    = '0;
      cand   = 0;
      c      = '0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         cand = int'(ptr) + off;
         if (cand >= NREQ) cand = cand - NREQ;
         c = PW'(cand);
         if (req[c]) begin
            valid     = 1'b1;
            onehot    = '0;
            onehot[c] = 1'b1;
            idx       = c;
         end
      end
   end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Shares one SPI serial transmitter between NREQ requesters.
// Grants round-robin, latches the winner's word, drives newd/din until the
// transmitter pulls cs low, then waits for cs high and reports completion.
// Ports:
//   clk      in  1        system clock
//   rst      in  1        asynchronous active-low reset
//   req      in  NREQ     level requests, dropped on gnt
//   wdata    in  NREQ*DW  requester i word at [i*DW +: DW]
//   gnt      out NREQ     one-cycle accept pulse
//   done     out NREQ     one-cycle transfer-finished pulse
//   err      out NREQ     one-cycle start-timeout abort pulse
//   busy     out 1        FSM not IDLE
//   spi_newd out 1        start request to transmitter
//   spi_din  out DW       word to transmitter
//   spi_cs   in  1        transmitter chip select, low = active
//
// state      | meaning
// IDLE       | arbitrate; issue when a request is pending and cs_s is high
// WAIT_START | newd held high, start timer running, waiting for cs_s low
// WAIT_END   | transfer in progress, waiting for cs_s to return high
module spi_tx_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NREQ          = 4,
   parameter int DW            = SPI_DW,
   parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic [NREQ-1:0]    err,
   output logic               busy,
   output logic               spi_newd,
   output logic [DW-1:0]      spi_din,
   input  logic               spi_cs
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(START_TIMEOUT + 1);

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   owner;
   logic [TW-1:0]   timer;
   logic            cs_s1;
   logic            cs_s;

   logic            pick_valid;
   logic [NREQ-1:0] pick_onehot;
   logic [PW-1:0]   pick_idx;

   spi_rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .valid  (pick_valid),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   assign busy = (state != IDLE);

   // Start timer is a down-counter loaded with START_TIMEOUT-1 on issue;
   // reaching zero while still waiting for cs is the abort point. It stops
   // at zero, so it can never wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ptr      <= '0;
         owner    <= '0;
         timer    <= '0;
         cs_s1    <= 1'b1;
         cs_s     <= 1'b1;
         gnt      <= '0;
         done     <= '0;
         err      <= '0;
         spi_newd <= 1'b0;
         spi_din  <= '0;
      end else begin
         cs_s1 <= spi_cs;
         cs_s  <= cs_s1;
         gnt   <= '0;
         done  <= '0;
         err   <= '0;
         case (state)
            IDLE: begin
               if (pick_valid && cs_s) begin
                  gnt      <= pick_onehot;
                  spi_din  <= wdata[int'(pick_idx)*DW +: DW];
                  spi_newd <= 1'b1;
                  timer    <= TW'(START_TIMEOUT - 1);
                  owner    <= pick_idx;
                  ptr      <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                  state    <= WAIT_START;
               end
            end
            WAIT_START: begin
               if (!cs_s) begin
                  spi_newd <= 1'b0;
                  state    <= WAIT_END;
               end else if (timer == '0) begin
                  spi_newd   <= 1'b0;
                  err[owner] <= 1'b1;
                  state      <= IDLE;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            WAIT_END: begin
               if (cs_s) begin
                  done[owner] <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: table-driven arbitration vectors
// plus hand-written sequences for timing, timeout, busy and reset cases.
module tb_spi_tx_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 12;
   localparam int TO   = 255;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req;
   logic [47:0]   wdata;
   logic [3:0]    gnt;
   logic [3:0]    done;
   logic [3:0]    err;
   logic          busy;
   logic          spi_newd;
   logic [11:0]   spi_din;
   logic          spi_cs;

   logic          cs_force;
   logic          cs_val;
   logic          cs_model;

   int total = 0;
   int bad   = 0;
   int mon_viol = 0;

   logic          prev_newd;
   logic [11:0]   prev_din;

   typedef struct {
      logic [3:0]  req;
      logic [47:0] wd;
      logic [3:0]  exp_gnt;
      logic [11:0] exp_din;
   } vec_t;

   vec_t tbl [12];

   assign spi_cs = cs_force ? cs_val : cs_model;

   always #5 clk = ~clk;

   spi_tx_arbiter #(
      .NREQ          (NREQ),
      .DW            (DW),
      .START_TIMEOUT (TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .wdata    (wdata),
      .gnt      (gnt),
      .done     (done),
      .err      (err),
      .busy     (busy),
      .spi_newd (spi_newd),
      .spi_din  (spi_din),
      .spi_cs   (spi_cs)
   );

   // Transmitter model: cs falls 3 clk after newd is seen, rises 6 clk later.
   always begin
      @(negedge clk);
      if (!cs_force && spi_newd && cs_model) begin
         repeat (3) @(negedge clk);
         cs_model = 1'b0;
         repeat (6) @(negedge clk);
         cs_model = 1'b1;
      end
   end

   // Every-cycle pulse integrity and din stability monitor.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (!$onehot0(gnt) || !$onehot0(done) || !$onehot0(err) ||
             !$onehot0({|gnt, |done, |err})) begin
            mon_viol++;
            if (mon_viol <= 5)
               $display("FAIL pulse_integrity t=%0t gnt=%b done=%b err=%b", $time, gnt, done, err);
         end
         if (prev_newd && spi_newd && spi_din !== prev_din) begin
            mon_viol++;
            if (mon_viol <= 5)
               $display("FAIL din_stable t=%0t actual=%h required=%h", $time, spi_din, prev_din);
         end
      end
      prev_newd <= spi_newd;
      prev_din  <= spi_din;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_gnt(input string name, input logic [3:0] exp, input int budget);
      int n;
      n = 0;
      while (1) begin
         @(negedge clk);
         n++;
         if (gnt != 0 || n >= budget) break;
      end
      check({name, "_gnt"}, gnt, exp);
   endtask

   task automatic wait_done(input string name, input logic [3:0] exp, input int budget);
      int n;
      n = 0;
      while (1) begin
         @(negedge clk);
         n++;
         if (done != 0 || n >= budget) break;
      end
      check({name, "_done"}, done, exp);
   endtask

   initial begin
      int seen;
      int early;

      tbl[0]  = '{4'b1111, 48'h4A3_3B2_2C1_1D0, 4'b0001, 12'h1D0};
      tbl[1]  = '{4'b1110, 48'h4A3_3B2_2C1_1D0, 4'b0010, 12'h2C1};
      tbl[2]  = '{4'b1100, 48'h4A3_3B2_2C1_1D0, 4'b0100, 12'h3B2};
      tbl[3]  = '{4'b1000, 48'h4A3_3B2_2C1_1D0, 4'b1000, 12'h4A3};
      tbl[4]  = '{4'b0011, 48'hF0E_D0C_B0A_908, 4'b0001, 12'h908};
      tbl[5]  = '{4'b0010, 48'hF0E_D0C_B0A_908, 4'b0010, 12'hB0A};
      tbl[6]  = '{4'b0101, 48'hF0E_D0C_B0A_908, 4'b0100, 12'hD0C};
      tbl[7]  = '{4'b0001, 48'hF0E_D0C_B0A_908, 4'b0001, 12'h908};
      tbl[8]  = '{4'b1001, 48'hF0E_D0C_B0A_908, 4'b1000, 12'hF0E};
      tbl[9]  = '{4'b0110, 48'h777_555_333_FFF, 4'b0010, 12'h333};
      tbl[10] = '{4'b1011, 48'h777_555_333_FFF, 4'b1000, 12'h777};
      tbl[11] = '{4'b0011, 48'h777_555_333_FFF, 4'b0001, 12'hFFF};

      rst      = 1'b0;
      req      = '0;
      wdata    = '0;
      cs_force = 1'b1;
      cs_val   = 1'b1;
      cs_model = 1'b1;
      step(3);
      check("rst_gnt", gnt, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      check("rst_newd", spi_newd, 0);
      check("rst_din", spi_din, 0);
      rst = 1'b1;
      step(2);

      // Table: arbitration order with the transmitter model driving cs.
      cs_force = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         req   = tbl[i].req;
         wdata = tbl[i].wd;
         wait_gnt($sformatf("tbl%0d", i), tbl[i].exp_gnt, 5);
         check($sformatf("tbl%0d_din", i), spi_din, tbl[i].exp_din);
         check($sformatf("tbl%0d_newd", i), spi_newd, 1);
         req = '0;
         wait_done($sformatf("tbl%0d", i), tbl[i].exp_gnt, 60);
         check($sformatf("tbl%0d_busy", i), busy, 0);
      end

      // Single transfer with exact cs timing (ptr=1, only req[0] active).
      cs_force = 1'b1;
      cs_val   = 1'b1;
      @(negedge clk);
      req   = 4'b0001;
      wdata = 48'h000_000_000_A5C;
      @(negedge clk);
      check("single_gnt", gnt, 4'b0001);
      check("single_newd_on", spi_newd, 1);
      req = '0;
      step(10);
      check("single_din_held", spi_din, 12'hA5C);
      check("single_newd_held", spi_newd, 1);
      cs_val = 1'b0;
      step(2);
      check("single_newd_sync", spi_newd, 1);
      step(1);
      check("single_newd_drop", spi_newd, 0);
      check("single_busy_mid", busy, 1);
      step(147);
      cs_val = 1'b1;
      step(2);
      check("single_done_early", done, 0);
      check("single_busy_end", busy, 1);
      step(1);
      check("single_done", done, 4'b0001);
      check("single_busy_idle", busy, 0);

      // Start timeout for requester 2 (ptr=1).
      @(negedge clk);
      req   = 4'b0100;
      wdata = 48'hF0E_D0C_B0A_908;
      wait_gnt("to", 4'b0100, 5);
      check("to_din", spi_din, 12'hD0C);
      req   = '0;
      early = 0;
      repeat (TO - 1) begin
         @(negedge clk);
         if (err != 0 || done != 0) early++;
      end
      check("to_no_early_pulse", early, 0);
      @(negedge clk);
      check("to_err", err, 4'b0100);
      check("to_done", done, 0);
      check("to_newd", spi_newd, 0);
      check("to_busy", busy, 0);

      // ptr must now be 3: requester 3 beats requester 0.
      cs_force = 1'b0;
      @(negedge clk);
      req = 4'b1001;
      wait_gnt("to_ptr", 4'b1000, 5);
      check("to_ptr_din", spi_din, 12'hF0E);
      req = '0;
      wait_done("to_ptr", 4'b1000, 60);

      // Request arriving while busy waits for the transfer to complete.
      cs_force = 1'b1;
      cs_val   = 1'b1;
      @(negedge clk);
      req   = 4'b0001;
      wdata = 48'h4A3_3B2_2C1_1D0;
      wait_gnt("busy0", 4'b0001, 5);
      req = '0;
      step(2);
      cs_val = 1'b0;
      step(5);
      check("busy_in_wait_end", {busy, spi_newd}, 2'b10);
      req  = 4'b0010;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (gnt != 0) seen++;
      end
      cs_val = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (gnt != 0) seen++;
      end
      @(negedge clk);
      check("busy_done0", done, 4'b0001);
      check("busy_gnt_with_done", gnt, 0);
      check("busy_no_early_gnt", seen, 0);
      @(negedge clk);
      check("busy_gnt1", gnt, 4'b0010);
      check("busy_din1", spi_din, 12'h2C1);
      req = '0;
      step(2);
      cs_val = 1'b0;
      step(4);
      cs_val = 1'b1;
      wait_done("busy1", 4'b0010, 10);

      // Reset during WAIT_END with cs held low.
      @(negedge clk);
      req   = 4'b0001;
      wdata = 48'h777_555_333_FFF;
      wait_gnt("rmid", 4'b0001, 5);
      req = '0;
      step(2);
      cs_val = 1'b0;
      step(5);
      check("rmid_busy_before", busy, 1);
      #2;
      rst = 1'b0;
      #1;
      check("rmid_outputs_zero", {gnt, done, err, busy, spi_newd, spi_din}, 0);
      @(negedge clk);
      rst = 1'b1;
      step(2);
      req  = 4'b1000;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (gnt != 0 || done != 0 || err != 0) seen++;
      end
      check("rmid_no_gnt_cs_low", seen, 0);
      check("rmid_idle_cs_low", busy, 0);
      cs_val = 1'b1;
      step(2);
      check("rmid_gnt_sync", gnt, 0);
      step(1);
      check("rmid_gnt3", gnt, 4'b1000);
      check("rmid_din3", spi_din, 12'h777);
      req = '0;
      step(2);
      cs_val = 1'b0;
      step(4);
      cs_val = 1'b1;
      wait_done("rmid", 4'b1000, 10);

      step(2);
      check("pulse_and_din_monitor", mon_viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
